// File: rtl/data_requester_pkg.sv
// rtl/data_requester_pkg.sv - shared protocol constants and requester state encoding
// Purpose: opcodes, burst length and FSM encoding shared by the requester and
//          the on-board responder.
// Ports:   none (package).
package data_requester_pkg;

    localparam logic [7:0] CMD_SINGLE  = 8'h04;
    localparam logic [7:0] CMD_BURST   = 8'h05;
    localparam logic [7:0] CMD_DROP    = 8'h42;
    localparam int         DATA_LENGTH = 116;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TX_CMD    = 3'd1,
        S_TX_GAP    = 3'd2,
        S_TX_ADDR   = 3'd3,
        S_TX_GAP2   = 3'd4,
        S_RX_BURST  = 3'd5,
        S_RX_SINGLE = 3'd6
    } req_state_t;

endpackage

// File: rtl/data_requester_tx_byte_handshake.sv
// rtl/data_requester_tx_byte_handshake.sv - one-byte UART tx handshake with guard gap
// Purpose: while i_req is high, wait for busy=0, then emit a one-cycle strobe
//          with the byte and hold off the next strobe for one gap cycle.
// Ports:   clk, rst       clock, async active-high reset
//          i_req          request a send (level, held by the caller)
//          i_byte         byte to send, captured when the strobe is issued
//          busy           UART tx busy
//          o_strobe       one-cycle tx strobe (registered)
//          o_data         tx byte, holds between strobes
module data_requester_tx_byte_handshake (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req,
    input  logic [7:0] i_byte,
    input  logic       busy,
    output logic       o_strobe,
    output logic [7:0] o_data
);

    logic       r_strobe;
    logic       r_gap;
    logic [7:0] r_data;
    logic       w_fire;

    // The gap register keeps a second strobe from being issued before the
    // UART has had a cycle to raise busy in response to the first one.
    assign w_fire = i_req && !busy && !r_strobe && !r_gap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_strobe <= 1'b0;
            r_gap    <= 1'b0;
            r_data   <= 8'h00;
        end else begin
            r_strobe <= w_fire;
            r_gap    <= r_strobe;
            if (w_fire) begin
                r_data <= i_byte;
            end
        end
    end

    assign o_strobe = r_strobe;
    assign o_data   = r_data;

endmodule

// File: rtl/data_requester.sv
// rtl/data_requester.sv - host-side command initiator and reply capture engine
// Purpose: sends burst/single/drop commands over a UART tx byte interface and
//          writes reply bytes from the UART rx interface into a capture RAM.
// Ports:   clk, rst                           clock, async active-high reset
//          start_burst/start_single/start_drop one-cycle requests (that priority)
//          single_addr                        address sampled with start_single
//          busy, new_data_tx, data_tx         UART tx side
//          new_data_rx, data_rx               UART rx side
//          wr_en, wr_addr, wr_data            capture RAM write port
//          done, timeout_err                  completion / abort pulses
//          bytes_rcvd                         bytes captured by this request
//          drop_mirror                        expected responder drop state
//          active                             high outside IDLE
module data_requester #(
    parameter int         DATA_LENGTH    = data_requester_pkg::DATA_LENGTH,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] CMD_SINGLE     = data_requester_pkg::CMD_SINGLE,
    parameter logic [7:0] CMD_BURST      = data_requester_pkg::CMD_BURST,
    parameter logic [7:0] CMD_DROP       = data_requester_pkg::CMD_DROP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_burst,
    input  logic       start_single,
    input  logic       start_drop,
    input  logic [7:0] single_addr,
    input  logic       busy,
    output logic       new_data_tx,
    output logic [7:0] data_tx,
    input  logic       new_data_rx,
    input  logic [7:0] data_rx,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       done,
    output logic       timeout_err,
    output logic [7:0] bytes_rcvd,
    output logic       drop_mirror,
    output logic       active
);

    import data_requester_pkg::*;

    localparam int             TW        = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]     LAST_BYTE = 8'(DATA_LENGTH - 1);

    req_state_t    r_state;
    logic [7:0]    r_opcode;
    logic [7:0]    r_addr;
    logic [TW-1:0] r_tmo;
    logic          r_wr_en;
    logic [7:0]    r_wr_addr;
    logic [7:0]    r_wr_data;
    logic          r_done;
    logic          r_tmo_err;
    logic [7:0]    r_bytes;
    logic          r_drop;

    logic          w_tmo_hit;
    logic          w_tx_req;
    logic [7:0]    w_tx_byte;
    logic          w_tx_strobe;

    assign w_tmo_hit = (r_tmo == TMO_LAST);
    // Requests are withheld in the terminal cycle so an abort never races a strobe.
    assign w_tx_req  = ((r_state == S_TX_CMD) || (r_state == S_TX_ADDR)) && !w_tmo_hit;
    assign w_tx_byte = (r_state == S_TX_ADDR) ? r_addr : r_opcode;

    data_requester_tx_byte_handshake u_tx_hs (
        .clk      (clk),
        .rst      (rst),
        .i_req    (w_tx_req),
        .i_byte   (w_tx_byte),
        .busy     (busy),
        .o_strobe (w_tx_strobe),
        .o_data   (data_tx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_opcode  <= 8'h00;
            r_addr    <= 8'h00;
            r_tmo     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 8'h00;
            r_wr_data <= 8'h00;
            r_done    <= 1'b0;
            r_tmo_err <= 1'b0;
            r_bytes   <= 8'h00;
            r_drop    <= 1'b0;
        end else begin
            r_wr_en   <= 1'b0;
            r_done    <= 1'b0;
            r_tmo_err <= 1'b0;
            r_tmo     <= r_tmo + 1'b1;

            case (r_state)
                S_IDLE: begin
                    r_tmo <= '0;
                    if (start_burst || start_single || start_drop) begin
                        r_bytes <= 8'h00;
                        r_state <= S_TX_CMD;
                        if (start_burst) begin
                            r_opcode <= CMD_BURST;
                        end else if (start_single) begin
                            r_opcode <= CMD_SINGLE;
                            r_addr   <= single_addr;
                        end else begin
                            r_opcode <= CMD_DROP;
                        end
                    end
                end

                S_TX_CMD, S_TX_ADDR: begin
                    // Strobe visible now: the byte is out, move to the gap cycle.
                    if (w_tx_strobe) begin
                        r_state <= (r_state == S_TX_CMD) ? S_TX_GAP : S_TX_GAP2;
                        r_tmo   <= '0;
                    end else if (w_tmo_hit) begin
                        r_state   <= S_IDLE;
                        r_done    <= 1'b1;
                        r_tmo_err <= 1'b1;
                        r_tmo     <= '0;
                    end
                end

                S_TX_GAP: begin
                    r_tmo <= '0;
                    if (r_opcode == CMD_SINGLE) begin
                        r_state <= S_TX_ADDR;
                    end else if (r_opcode == CMD_BURST) begin
                        r_state <= S_RX_BURST;
                    end else begin
                        r_drop  <= ~r_drop;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end

                S_TX_GAP2: begin
                    r_tmo   <= '0;
                    r_state <= S_RX_SINGLE;
                end

                S_RX_BURST: begin
                    // An rx byte takes priority over the terminal timeout cycle.
                    if (new_data_rx) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_bytes;
                        r_wr_data <= data_rx;
                        r_bytes   <= r_bytes + 8'd1;
                        r_tmo     <= '0;
                        if (r_bytes == LAST_BYTE) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else if (w_tmo_hit) begin
                        r_state   <= S_IDLE;
                        r_done    <= 1'b1;
                        r_tmo_err <= 1'b1;
                        r_tmo     <= '0;
                    end
                end

                S_RX_SINGLE: begin
                    if (new_data_rx) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_addr;
                        r_wr_data <= data_rx;
                        r_bytes   <= 8'd1;
                        r_done    <= 1'b1;
                        r_state   <= S_IDLE;
                        r_tmo     <= '0;
                    end else if (w_tmo_hit) begin
                        r_state   <= S_IDLE;
                        r_done    <= 1'b1;
                        r_tmo_err <= 1'b1;
                        r_tmo     <= '0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_tmo   <= '0;
                end
            endcase
        end
    end

    assign new_data_tx = w_tx_strobe;
    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign done        = r_done;
    assign timeout_err = r_tmo_err;
    assign bytes_rcvd  = r_bytes;
    assign drop_mirror = r_drop;
    assign active      = (r_state != S_IDLE);

endmodule

// File: tb/tb_data_requester.sv
// tb/tb_data_requester.sv - directed self-checking bench for data_requester
module tb_data_requester;

    localparam int T = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_burst;
    logic       start_single;
    logic       start_drop;
    logic [7:0] single_addr;
    logic       busy;
    logic       new_data_tx;
    logic [7:0] data_tx;
    logic       new_data_rx;
    logic [7:0] data_rx;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       done;
    logic       timeout_err;
    logic [7:0] bytes_rcvd;
    logic       drop_mirror;
    logic       active;

    int checks = 0;
    int errors = 0;
    int n_strobe = 0;
    int n_wr = 0;
    int n_done = 0;
    logic [7:0] last_strobe = 8'h00;

    always #5 clk = ~clk;

    data_requester #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_burst  (start_burst),
        .start_single (start_single),
        .start_drop   (start_drop),
        .single_addr  (single_addr),
        .busy         (busy),
        .new_data_tx  (new_data_tx),
        .data_tx      (data_tx),
        .new_data_rx  (new_data_rx),
        .data_rx      (data_rx),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .done         (done),
        .timeout_err  (timeout_err),
        .bytes_rcvd   (bytes_rcvd),
        .drop_mirror  (drop_mirror),
        .active       (active)
    );

    always @(posedge clk) begin
        if (!rst) begin
            if (new_data_tx) begin
                n_strobe++;
                last_strobe = data_tx;
            end
            if (wr_en) n_wr++;
            if (done) n_done++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input logic b, input logic s, input logic d);
        start_burst = b; start_single = s; start_drop = d;
        step(1);
        start_burst = 1'b0; start_single = 1'b0; start_drop = 1'b0;
    endtask

    task automatic feed(input logic [7:0] v);
        new_data_rx = 1'b1; data_rx = v;
        step(1);
        new_data_rx = 1'b0;
    endtask

    task automatic wait_for_strobe(input int limit, output int k);
        k = 0;
        while (new_data_tx !== 1'b1 && k < limit) begin
            step(1);
            k++;
        end
    endtask

    task automatic wait_for_done(input int limit, output int k);
        k = 0;
        while (done !== 1'b1 && k < limit) begin
            step(1);
            k++;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tx"},     {31'd0, new_data_tx}, 32'd0);
        chk({tag, "_txd"},    {24'd0, data_tx},     32'd0);
        chk({tag, "_wr"},     {31'd0, wr_en},       32'd0);
        chk({tag, "_wra"},    {24'd0, wr_addr},     32'd0);
        chk({tag, "_wrd"},    {24'd0, wr_data},     32'd0);
        chk({tag, "_done"},   {31'd0, done},        32'd0);
        chk({tag, "_tmo"},    {31'd0, timeout_err}, 32'd0);
        chk({tag, "_bytes"},  {24'd0, bytes_rcvd},  32'd0);
        chk({tag, "_drop"},   {31'd0, drop_mirror}, 32'd0);
        chk({tag, "_active"}, {31'd0, active},      32'd0);
    endtask

    initial begin
        int k;
        int gap;
        int b_strobe, b_wr, b_done;

        rst = 1'b1; start_burst = 1'b0; start_single = 1'b0; start_drop = 1'b0;
        single_addr = 8'h00; busy = 1'b0; new_data_rx = 1'b0; data_rx = 8'h00;
        step(2);
        chk_all_zero("reset");
        rst = 1'b0;
        step(1);

        // Burst happy path
        b_strobe = n_strobe; b_wr = n_wr; b_done = n_done;
        pulse_start(1'b1, 1'b0, 1'b0);
        chk("burst_active", {31'd0, active}, 32'd1);
        wait_for_strobe(20, k);
        chk("burst_strobe", {31'd0, new_data_tx}, 32'd1);
        chk("burst_opcode", {24'd0, data_tx}, 32'h05);
        step(1);
        chk("burst_strobe_one", {31'd0, new_data_tx}, 32'd0);
        chk("burst_txd_hold", {24'd0, data_tx}, 32'h05);
        step(2);
        for (int i = 0; i < 116; i++) begin
            feed(8'(i));
            chk("burst_wr_en", {31'd0, wr_en}, 32'd1);
            chk("burst_wr_addr", {24'd0, wr_addr}, 32'(i));
            chk("burst_wr_data", {24'd0, wr_data}, 32'(i));
            chk("burst_done", {31'd0, done}, (i == 115) ? 32'd1 : 32'd0);
            chk("burst_bytes", {24'd0, bytes_rcvd}, 32'(i + 1));
            chk("burst_tmo", {31'd0, timeout_err}, 32'd0);
            if (i < 115) step(4);
        end
        chk("burst_idle", {31'd0, active}, 32'd0);
        step(1);
        chk("burst_done_one", {31'd0, done}, 32'd0);
        chk("burst_n_wr", 32'(n_wr - b_wr), 32'd116);
        chk("burst_n_done", 32'(n_done - b_done), 32'd1);
        chk("burst_n_strobe", 32'(n_strobe - b_strobe), 32'd1);
        feed(8'h99);
        chk("after_burst_no_wr", {31'd0, wr_en}, 32'd0);
        chk("after_burst_bytes", {24'd0, bytes_rcvd}, 32'd116);

        // Single read with tx backpressure
        b_strobe = n_strobe; b_wr = n_wr;
        busy = 1'b1;
        single_addr = 8'h23;
        pulse_start(1'b0, 1'b1, 1'b0);
        single_addr = 8'h77;
        step(9);
        chk("single_bp_no_strobe", 32'(n_strobe - b_strobe), 32'd0);
        chk("single_bp_tx", {31'd0, new_data_tx}, 32'd0);
        busy = 1'b0;
        wait_for_strobe(20, k);
        chk("single_strobe1", {31'd0, new_data_tx}, 32'd1);
        chk("single_opcode", {24'd0, data_tx}, 32'h04);
        step(1);
        wait_for_strobe(20, k);
        gap = k + 1;
        chk("single_strobe2", {31'd0, new_data_tx}, 32'd1);
        chk("single_addr_byte", {24'd0, data_tx}, 32'h23);
        chk("single_gap_ge2", {31'd0, gap >= 2}, 32'd1);
        step(3);
        feed(8'hA5);
        chk("single_wr_en", {31'd0, wr_en}, 32'd1);
        chk("single_wr_addr", {24'd0, wr_addr}, 32'h23);
        chk("single_wr_data", {24'd0, wr_data}, 32'hA5);
        chk("single_done", {31'd0, done}, 32'd1);
        chk("single_bytes", {24'd0, bytes_rcvd}, 32'd1);
        chk("single_tmo", {31'd0, timeout_err}, 32'd0);
        step(1);
        chk("single_n_strobe", 32'(n_strobe - b_strobe), 32'd2);
        chk("single_n_wr", 32'(n_wr - b_wr), 32'd1);

        // Timeout after 10 bytes
        pulse_start(1'b1, 1'b0, 1'b0);
        wait_for_strobe(20, k);
        step(3);
        for (int i = 0; i < 10; i++) begin
            feed(8'(i));
            if (i < 9) step(1);
        end
        wait_for_done(100, k);
        chk("tmo_latency", 32'(k), 32'd64);
        chk("tmo_err", {31'd0, timeout_err}, 32'd1);
        chk("tmo_bytes", {24'd0, bytes_rcvd}, 32'd10);
        chk("tmo_idle", {31'd0, active}, 32'd0);
        step(1);
        chk("tmo_err_one", {31'd0, timeout_err}, 32'd0);

        // Next burst accepted; byte in terminal cycle wins
        pulse_start(1'b1, 1'b0, 1'b0);
        chk("tmo_restart_active", {31'd0, active}, 32'd1);
        wait_for_strobe(20, k);
        chk("tmo_restart_opcode", {24'd0, data_tx}, 32'h05);
        step(3);
        feed(8'h11);
        chk("term_first_addr", {24'd0, wr_addr}, 32'd0);
        step(63);
        chk("term_still_active", {31'd0, active}, 32'd1);
        chk("term_no_done_yet", {31'd0, done}, 32'd0);
        feed(8'h22);
        chk("term_wr_en", {31'd0, wr_en}, 32'd1);
        chk("term_wr_addr", {24'd0, wr_addr}, 32'd1);
        chk("term_wr_data", {24'd0, wr_data}, 32'h22);
        chk("term_no_done", {31'd0, done}, 32'd0);
        chk("term_no_tmo", {31'd0, timeout_err}, 32'd0);
        chk("term_bytes", {24'd0, bytes_rcvd}, 32'd2);
        wait_for_done(100, k);
        chk("term_tmo_latency", 32'(k), 32'd64);
        chk("term_tmo_err", {31'd0, timeout_err}, 32'd1);
        chk("term_tmo_bytes", {24'd0, bytes_rcvd}, 32'd2);
        step(1);

        // busy stuck high aborts in TX_CMD
        b_strobe = n_strobe;
        busy = 1'b1;
        pulse_start(1'b1, 1'b0, 1'b0);
        wait_for_done(100, k);
        chk("busy_tmo_latency", 32'(k), 32'd64);
        chk("busy_tmo_err", {31'd0, timeout_err}, 32'd1);
        chk("busy_tmo_drop", {31'd0, drop_mirror}, 32'd0);
        step(1);
        chk("busy_tmo_no_strobe", 32'(n_strobe - b_strobe), 32'd0);
        busy = 1'b0;
        step(1);

        // Drop toggle twice
        for (int r = 0; r < 2; r++) begin
            b_strobe = n_strobe; b_wr = n_wr;
            chk("drop_before", {31'd0, drop_mirror}, 32'(r));
            pulse_start(1'b0, 1'b0, 1'b1);
            wait_for_done(20, k);
            chk("drop_done", {31'd0, done}, 32'd1);
            chk("drop_after", {31'd0, drop_mirror}, 32'(1 - r));
            chk("drop_tmo", {31'd0, timeout_err}, 32'd0);
            step(1);
            chk("drop_n_strobe", 32'(n_strobe - b_strobe), 32'd1);
            chk("drop_opcode", {24'd0, last_strobe}, 32'h42);
            chk("drop_no_wr", 32'(n_wr - b_wr), 32'd0);
        end

        // Priority, ignored mid-burst start, stray rx in IDLE
        b_strobe = n_strobe; b_wr = n_wr;
        pulse_start(1'b1, 1'b0, 1'b1);
        wait_for_strobe(20, k);
        chk("prio_opcode", {24'd0, data_tx}, 32'h05);
        step(3);
        single_addr = 8'h23;
        pulse_start(1'b0, 1'b1, 1'b0);
        chk("prio_mid_active", {31'd0, active}, 32'd1);
        wait_for_done(100, k);
        chk("prio_tmo", {31'd0, timeout_err}, 32'd1);
        step(1);
        chk("prio_n_strobe", 32'(n_strobe - b_strobe), 32'd1);
        chk("prio_drop", {31'd0, drop_mirror}, 32'd0);
        chk("prio_no_wr", 32'(n_wr - b_wr), 32'd0);
        feed(8'h5A);
        chk("idle_rx_no_wr", {31'd0, wr_en}, 32'd0);
        step(1);
        chk("idle_rx_n_wr", 32'(n_wr - b_wr), 32'd0);
        chk("idle_rx_active", {31'd0, active}, 32'd0);

        // Reset mid-burst
        pulse_start(1'b0, 1'b0, 1'b1);
        wait_for_done(20, k);
        chk("pre_rst_drop", {31'd0, drop_mirror}, 32'd1);
        step(1);
        b_done = n_done;
        pulse_start(1'b1, 1'b0, 1'b0);
        wait_for_strobe(20, k);
        step(3);
        for (int i = 0; i < 50; i++) begin
            feed(8'(i + 8'h30));
            step(1);
        end
        chk("pre_rst_bytes", {24'd0, bytes_rcvd}, 32'd50);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        step(2);
        rst = 1'b0;
        step(2);
        chk("midrst_no_done", 32'(n_done - b_done), 32'd0);
        pulse_start(1'b1, 1'b0, 1'b0);
        chk("post_rst_bytes0", {24'd0, bytes_rcvd}, 32'd0);
        wait_for_strobe(20, k);
        step(3);
        for (int i = 0; i < 3; i++) begin
            feed(8'(8'hC0 + i));
            chk("post_rst_wr_addr", {24'd0, wr_addr}, 32'(i));
            chk("post_rst_wr_data", {24'd0, wr_data}, 32'(8'hC0 + i));
            chk("post_rst_bytes", {24'd0, bytes_rcvd}, 32'(i + 1));
            step(1);
        end
        rst = 1'b1;
        step(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
